// File: rtl/counter_pulse_driver.sv
// Meters a signed balance of up/down requests into spaced inc/dec pulses for a
// saturating counter, tracking a shadow of the counter to avoid pulsing into a rail.
module counter_pulse_driver #(
    parameter int              N       = 8,
    parameter logic [N-1:0]    SET_VAL = {N{1'b0}},
    parameter int              PEND_W  = 4,
    parameter int              HOLDOFF = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_req,
    input  logic              down_req,
    input  logic              clear,
    output logic              inc,
    output logic              dec,
    output logic              setval,
    output logic [PEND_W-1:0] pending,
    output logic [N-1:0]      shadow,
    output logic              busy
);

    localparam int HC_W      = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;
    localparam int PEND_MAX  = (2 ** (PEND_W - 1)) - 1;
    localparam int PEND_MIN  = -(2 ** (PEND_W - 1));

    typedef enum logic [0:0] {
        ST_READY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t            state_r, state_s;
    logic [HC_W-1:0]   hold_r, hold_s;
    logic [PEND_W-1:0] pending_r, pending_s;
    logic [N-1:0]      shadow_r, shadow_s;
    logic              inc_r, inc_s;
    logic              dec_r, dec_s;
    logic              setval_r, setval_s;
    logic              launch_s;
    logic              stale_s;
    int                pend_i;
    int                delta_i;
    int                issued_i;

    function automatic logic [PEND_W-1:0] sat_pend(input int v);
        if (v > PEND_MAX) begin
            return PEND_W'(PEND_MAX);
        end else if (v < PEND_MIN) begin
            return PEND_W'(PEND_MIN);
        end else begin
            return PEND_W'(v);
        end
    endfunction

    // Next-state: clear overrides everything; otherwise READY may launch one pulse.
    always_comb begin
        state_s   = state_r;
        hold_s    = hold_r;
        pending_s = pending_r;
        shadow_s  = shadow_r;
        inc_s     = 1'b0;
        dec_s     = 1'b0;
        setval_s  = 1'b0;
        launch_s  = 1'b0;
        stale_s   = 1'b0;
        issued_i  = 32'sd0;
        pend_i    = int'($signed(pending_r));

        if (up_req && !down_req) begin
            delta_i = 32'sd1;
        end else if (down_req && !up_req) begin
            delta_i = -32'sd1;
        end else begin
            delta_i = 32'sd0;
        end

        if (clear) begin
            setval_s  = 1'b1;
            pending_s = {PEND_W{1'b0}};
            shadow_s  = SET_VAL;
            launch_s  = 1'b1;
        end else begin
            case (state_r)
                ST_READY: begin
                    if (pend_i > 32'sd0) begin
                        if (!(&shadow_r)) begin
                            inc_s    = 1'b1;
                            shadow_s = shadow_r + {{(N-1){1'b0}}, 1'b1};
                            issued_i = 32'sd1;
                            launch_s = 1'b1;
                        end else begin
                            stale_s = 1'b1;
                        end
                    end else if (pend_i < 32'sd0) begin
                        if (shadow_r != {N{1'b0}}) begin
                            dec_s    = 1'b1;
                            shadow_s = shadow_r - {{(N-1){1'b0}}, 1'b1};
                            issued_i = -32'sd1;
                            launch_s = 1'b1;
                        end else begin
                            stale_s = 1'b1;
                        end
                    end else begin
                        stale_s = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (hold_r == {HC_W{1'b0}}) begin
                        state_s = ST_READY;
                    end else begin
                        hold_s = hold_r - {{(HC_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_s = ST_READY;
                    hold_s  = {HC_W{1'b0}};
                end
            endcase

            // A balance pointing into a saturated counter is meaningless; keep only this cycle's request.
            if (stale_s) begin
                pending_s = PEND_W'(delta_i);
            end else begin
                pending_s = sat_pend(pend_i + delta_i - issued_i);
            end
        end

        if (launch_s) begin
            if (HOLDOFF > 1) begin
                state_s = ST_HOLD;
                hold_s  = HC_W'(HOLDOFF - 2);
            end else begin
                state_s = ST_READY;
                hold_s  = {HC_W{1'b0}};
            end
        end else begin
            launch_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_READY;
            hold_r    <= {HC_W{1'b0}};
            pending_r <= {PEND_W{1'b0}};
            shadow_r  <= {1'b1, {(N-1){1'b0}}};
            inc_r     <= 1'b0;
            dec_r     <= 1'b0;
            setval_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            hold_r    <= hold_s;
            pending_r <= pending_s;
            shadow_r  <= shadow_s;
            inc_r     <= inc_s;
            dec_r     <= dec_s;
            setval_r  <= setval_s;
        end
    end

    assign inc     = inc_r;
    assign dec     = dec_r;
    assign setval  = setval_r;
    assign pending = pending_r;
    assign shadow  = shadow_r;
    assign busy    = (pending_r != {PEND_W{1'b0}}) || (state_r == ST_HOLD);

endmodule

// File: tb/tb_counter_pulse_driver.sv
// Bench for counter_pulse_driver: timestamp-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_counter_pulse_driver;

    localparam int           N       = 8;
    localparam logic [N-1:0] SET_VAL = 8'h00;
    localparam int           PEND_W  = 4;
    localparam int           HOLDOFF = 4;

    logic              clk;
    logic              rst;
    logic              up_req;
    logic              down_req;
    logic              clear;
    logic              inc;
    logic              dec;
    logic              setval;
    logic [PEND_W-1:0] pending;
    logic [N-1:0]      shadow;
    logic              busy;

    int n_cmp  = 0;
    int n_fail = 0;

    counter_pulse_driver #(
        .N       (N),
        .SET_VAL (SET_VAL),
        .PEND_W  (PEND_W),
        .HOLDOFF (HOLDOFF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .up_req   (up_req),
        .down_req (down_req),
        .clear    (clear),
        .inc      (inc),
        .dec      (dec),
        .setval   (setval),
        .pending  (pending),
        .shadow   (shadow),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pend_val();
        return int'($signed(pending));
    endfunction

    // Reference model: pulse starts are timestamped; a new one is allowed once
    // HOLDOFF cycles have elapsed since the previous start (setval counts as a start).
    int m_pend, m_shadow, m_last, cyc, m_d, m_iss;
    logic m_inc, m_dec, m_set, m_stale;
    initial begin
        cyc = 0;
        m_last = -1000;
        m_pend = 0;
        m_shadow = 128;
        m_inc = 1'b0; m_dec = 1'b0; m_set = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_inc = 1'b0; m_dec = 1'b0; m_set = 1'b0;
                m_pend = 0; m_shadow = 128; m_last = -1000;
            end else begin
                m_inc = 1'b0; m_dec = 1'b0; m_set = 1'b0;
                m_d = (up_req && !down_req) ? 1 : ((down_req && !up_req) ? -1 : 0);
                if (clear) begin
                    m_set = 1'b1; m_pend = 0; m_shadow = int'(SET_VAL); m_last = cyc + 1;
                end else begin
                    m_iss = 0;
                    m_stale = 1'b0;
                    if (cyc + 1 >= m_last + HOLDOFF) begin
                        if (m_pend > 0 && m_shadow == 255) m_stale = 1'b1;
                        else if (m_pend < 0 && m_shadow == 0) m_stale = 1'b1;
                        else if (m_pend > 0) begin
                            m_inc = 1'b1; m_shadow++; m_iss = 1; m_last = cyc + 1;
                        end else if (m_pend < 0) begin
                            m_dec = 1'b1; m_shadow--; m_iss = -1; m_last = cyc + 1;
                        end
                    end
                    if (m_stale) m_pend = m_d;
                    else begin
                        m_pend = m_pend + m_d - m_iss;
                        if (m_pend > 7) m_pend = 7;
                        if (m_pend < -8) m_pend = -8;
                    end
                end
            end
            cyc++;
            #2;
            check("m_inc", inc, m_inc);
            check("m_dec", dec, m_dec);
            check("m_setval", setval, m_set);
            check("m_pending", pend_val(), m_pend);
            check("m_shadow", shadow, m_shadow);
            check("m_busy", busy, (m_pend != 0 || cyc < m_last + HOLDOFF - 1) ? 1 : 0);
        end
    end

    task automatic step(input logic u, input logic d, input logic c);
        @(posedge clk);
        #1;
        up_req = u; down_req = d; clear = c;
        @(negedge clk);
    endtask

    int peak, lowest;

    initial begin
        rst = 1'b1; up_req = 1'b0; down_req = 1'b0; clear = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_inc", inc, 0);
        check("rst_dec", dec, 0);
        check("rst_setval", setval, 0);
        check("rst_pending", pend_val(), 0);
        check("rst_shadow", shadow, 8'h80);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Burst of three requests: pulses at +2, +6, +10.
        peak = 0;
        for (int i = 0; i < 16; i++) begin
            step(logic'(i < 3), 1'b0, 1'b0);
            check("burst_inc", inc, (i == 2 || i == 6 || i == 10) ? 1 : 0);
            if (pend_val() > peak) peak = pend_val();
            if (i == 12) check("burst_busy_hi", busy, 1);
            if (i == 13) check("burst_busy_lo", busy, 0);
        end
        check("burst_peak", peak, 2);
        check("burst_shadow", shadow, 8'h83);

        // Simultaneous up and down cancel.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0);
            check("cancel_pend", pend_val(), 0);
            check("cancel_pulse", int'(inc | dec), 0);
            check("cancel_busy", busy, 0);
        end
        step(1'b0, 1'b0, 1'b0);
        check("cancel_pend_end", pend_val(), 0);

        // Balance saturation.
        peak = 0; lowest = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (pend_val() > peak) peak = pend_val();
            if (pend_val() < lowest) lowest = pend_val();
        end
        step(1'b0, 1'b0, 1'b0);
        check("sat_pend_hold", pend_val(), 7);
        check("sat_peak", peak, 7);
        check("sat_nonneg", lowest, 0);
        for (int i = 0; i < 100 && busy; i++) step(1'b0, 1'b0, 1'b0);
        check("sat_drain_busy", busy, 0);

        // Floor: clear then one down request never produces a dec.
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        check("floor_setval", setval, 1);
        check("floor_shadow", shadow, 0);
        check("floor_pend0", pend_val(), 0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (i == 0) check("floor_pend_neg", pend_val(), -1);
            if (i == 0) check("floor_setval_lo", setval, 0);
            check("floor_dec", dec, 0);
        end
        check("floor_pend_end", pend_val(), 0);

        // Clear in the middle of a holdoff restarts the spacing.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check("mid_inc", inc, (i == 2) ? 1 : 0);
        end
        step(1'b0, 1'b0, 1'b1);
        check("mid_pend3", pend_val(), 3);
        check("mid_busy", busy, 1);
        step(1'b1, 1'b0, 1'b0);
        check("mid_setval", setval, 1);
        check("mid_pend0", pend_val(), 0);
        for (int i = 6; i < 13; i++) begin
            step(1'b0, 1'b0, 1'b0);
            check("mid_inc_after", inc, (i == 9) ? 1 : 0);
        end
        for (int i = 0; i < 100 && busy; i++) step(1'b0, 1'b0, 1'b0);
        check("mid_drain_busy", busy, 0);

        // Down pulses from a non-zero shadow.
        for (int i = 0; i < 10; i++) begin
            step(logic'(i == 0), logic'(i >= 5 && i < 7), 1'b0);
        end
        for (int i = 0; i < 100 && busy; i++) step(1'b0, 1'b0, 1'b0);
        check("down_drain_busy", busy, 0);

        @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
